// File: rtl/raster_pkg.sv
// Shared constants and state encoding for the triangle rasterizer.
// COORD_W: default coordinate width; AREA_W: exact signed area width.
package raster_pkg;
  localparam int COORD_W = 12;
  localparam int AREA_W = 2 * COORD_W + 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCAN,
    EMIT,
    DONE
  } state_t;
endpackage

// File: rtl/triangle_raster_edge_area.sv
// edge_area: exact signed doubled area of triangle (a, b, c).
// Ports: ax..cy vertex coordinates in, area full-precision signed out.
module edge_area #(
  parameter int CW = raster_pkg::COORD_W,
  parameter int AW = raster_pkg::AREA_W
) (
  input  logic signed [CW-1:0] ax,
  input  logic signed [CW-1:0] ay,
  input  logic signed [CW-1:0] bx,
  input  logic signed [CW-1:0] by,
  input  logic signed [CW-1:0] cx,
  input  logic signed [CW-1:0] cy,
  output logic signed [AW-1:0] area
);
  logic signed [AW-1:0] eax, eay, ebx, eby, ecx, ecy;

  // sign-extend before multiplying so no product or sum is truncated
  assign eax = AW'(ax);
  assign eay = AW'(ay);
  assign ebx = AW'(bx);
  assign eby = AW'(by);
  assign ecx = AW'(cx);
  assign ecy = AW'(cy);

  assign area = eax * eby - eay * ebx
              + eay * ecx - eax * ecy
              + ebx * ecy - eby * ecx;
endmodule

// File: rtl/triangle_raster.sv
// Bounding-box rasterizer: emits strictly interior pixels of a CCW triangle.
// Ports: start/vertices in, px/py + out_valid/out_ready stream, busy, done.
module triangle_raster #(
  parameter int COORD_W = raster_pkg::COORD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] ax,
  input  logic signed [COORD_W-1:0] ay,
  input  logic signed [COORD_W-1:0] bx,
  input  logic signed [COORD_W-1:0] by,
  input  logic signed [COORD_W-1:0] cx,
  input  logic signed [COORD_W-1:0] cy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] px,
  output logic signed [COORD_W-1:0] py,
  output logic                      busy,
  output logic                      done
);
  import raster_pkg::*;

  localparam int CW = COORD_W;

  typedef logic signed [CW-1:0] crd_t;

  function automatic crd_t min3(crd_t a, crd_t b, crd_t c);
    crd_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic crd_t max3(crd_t a, crd_t b, crd_t c);
    crd_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t state;
  crd_t   vax, vay, vbx, vby, vcx, vcy;
  crd_t   xmin, xmax, ymax;
  crd_t   x, y, nx, ny;
  logic   covered, last;

  logic signed [AREA_W-1:0] a0, a1, a2;

  edge_area #(.CW(CW), .AW(AREA_W)) u_pbc (
    .ax(x),   .ay(y),
    .bx(vbx), .by(vby),
    .cx(vcx), .cy(vcy),
    .area(a0)
  );

  edge_area #(.CW(CW), .AW(AREA_W)) u_apc (
    .ax(vax), .ay(vay),
    .bx(x),   .by(y),
    .cx(vcx), .cy(vcy),
    .area(a1)
  );

  edge_area #(.CW(CW), .AW(AREA_W)) u_abp (
    .ax(vax), .ay(vay),
    .bx(vbx), .by(vby),
    .cx(x),   .cy(y),
    .area(a2)
  );

  // strict test: edges, CW and degenerate triangles cover nothing
  assign covered = (a0 > 0) && (a1 > 0) && (a2 > 0);
  assign last = (x == xmax) && (y == ymax);

  // row-major successor of the current candidate
  always_comb begin
    nx = x + crd_t'(1);
    ny = y;
    if (x == xmax) begin
      nx = xmin;
      ny = y + crd_t'(1);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      px        <= '0;
      py        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vax   <= ax;
            vay   <= ay;
            vbx   <= bx;
            vby   <= by;
            vcx   <= cx;
            vcy   <= cy;
            state <= SETUP;
          end
        end
        SETUP: begin
          xmin  <= min3(vax, vbx, vcx);
          xmax  <= max3(vax, vbx, vcx);
          ymax  <= max3(vay, vby, vcy);
          x     <= min3(vax, vbx, vcx);
          y     <= min3(vay, vby, vcy);
          state <= SCAN;
        end
        SCAN: begin
          if (covered) begin
            px        <= x;
            py        <= y;
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (last) begin
            state <= DONE;
          end else begin
            x <= nx;
            y <= ny;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              state <= DONE;
            end else begin
              x     <= nx;
              y     <= ny;
              state <= SCAN;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_triangle_raster.sv
// Directed scoreboard bench for triangle_raster.
// Expected pixels are queued at launch and popped on each handshake.
module tb_triangle_raster;
  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic signed [11:0] ax, ay, bx, by, cx, cy;
  logic signed [11:0] px, py;
  logic out_valid, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int qx[$];
  int qy[$];

  always #5 clk = ~clk;

  triangle_raster #(.COORD_W(12)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .out_valid(out_valid), .out_ready(out_ready),
    .px(px), .py(py), .busy(busy), .done(done)
  );

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // observe the current cycle, then advance one clock
  task automatic tick();
    int ex, ey;
    if (out_valid && out_ready) begin
      if (qx.size() == 0) begin
        chk("extra_pixel", 1, 0);
      end else begin
        ex = qx.pop_front();
        ey = qy.pop_front();
        chk("px", int'(px), ex);
        chk("py", int'(py), ey);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_px(int x, int y);
    qx.push_back(x);
    qy.push_back(y);
  endtask

  task automatic set_tri(int a_x, int a_y, int b_x, int b_y,
                         int c_x, int c_y);
    ax = 12'(a_x); ay = 12'(a_y);
    bx = 12'(b_x); by = 12'(b_y);
    cx = 12'(c_x); cy = 12'(c_y);
  endtask

  task automatic launch(int a_x, int a_y, int b_x, int b_y,
                        int c_x, int c_y);
    done_cnt = 0;
    done_cyc = -1;
    set_tri(a_x, a_y, b_x, b_y, c_x, c_y);
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_tri(string tag, int exp_cyc);
    int n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    tick();
    tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_all_pixels"}, qx.size(), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    if (exp_cyc >= 0) chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, int'(out_valid), 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    set_tri(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_px", int'(px), 0);

    // basic CCW triangle
    expect_px(1, 1); expect_px(2, 1); expect_px(1, 2);
    launch(0, 0, 4, 0, 0, 4);
    chk("busy_setup", int'(busy), 1);
    finish_tri("basic", 30);

    // negative coordinates
    expect_px(-1, -1); expect_px(0, -1); expect_px(-1, 0);
    launch(-2, -2, 2, -2, -2, 2);
    finish_tri("neg", 30);

    // clockwise and collinear emit nothing
    launch(0, 0, 0, 4, 4, 0);
    finish_tri("cw", 27);
    launch(0, 0, 2, 2, 4, 4);
    finish_tri("collinear", 27);

    // single-point bounding box
    launch(3, 3, 3, 3, 3, 3);
    finish_tri("point", 3);

    // consumer stall on the first pixel
    expect_px(1, 1); expect_px(2, 1); expect_px(1, 2);
    out_ready = 1'b0;
    launch(0, 0, 4, 0, 0, 4);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_px", int'(px), 1);
      chk("stall_py", int'(py), 1);
      tick();
    end
    out_ready = 1'b1;
    finish_tri("stall", 35);

    // reset while in EMIT, then a clean restart
    expect_px(1, 1);
    out_ready = 1'b0;
    launch(0, 0, 4, 0, 0, 4);
    wait_valid("emit_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_px", int'(px), 0);
    chk("mid_rst_py", int'(py), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    qx.delete();
    qy.delete();
    out_ready = 1'b1;
    expect_px(1, 1); expect_px(2, 1); expect_px(1, 2);
    launch(0, 0, 4, 0, 0, 4);
    finish_tri("restart", 30);

    // restart request and vertex change during SCAN are ignored
    expect_px(1, 1); expect_px(2, 1); expect_px(1, 2);
    launch(0, 0, 4, 0, 0, 4);
    repeat (4) tick();
    set_tri(0, 0, 0, 4, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_tri("restart_ignored", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
